rvv_backend_retire_byte_merge: RTL and testbench
================================================

Name: rvv_backend_retire_byte_merge

Overview:
- Consumes the per-byte operand classification that dispatch attaches to each uop: BODY_ACTIVE, BODY_INACTIVE, TAIL or NOT_CHANGE, plus the v0 strobe.
- Applies the vta/vma policy and produces the final VRF write data and byte enables at retire.
- Mask-destination instructions (EEW1 vd) are split across several uops. For these, the block accumulates strobed result bits over all uops and issues a single merged VRF write on the last uop.
- Sits between the ROB retire port and the VRF write port. Valid/ready on both sides, one pipeline register.

Parameters:
- VLENB, 16, bytes per vector register (VLEN = VLENB*8).
- VL_WIDTH, $clog2(VLENB*8)+1, width of vl.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  retire uop valid.
- in_ready  output  1  block accepts uop this cycle.
- in_vd_addr  input  5  destination register index.
- in_result  input  VLENB*8  execution result (packed mask bits when in_mask_dst).
- in_old_vd  input  VLENB*8  current VRF contents of vd.
- in_vd_type  input  VLENB*2  BYTE_TYPE_t per byte.
- in_mask_strobe  input  VLENB*8  per-bit valid of in_result (mask mode only).
- in_vta  input  1  tail agnostic.
- in_vma  input  1  mask agnostic.
- in_mask_dst  input  1  uop writes a mask register.
- in_last  input  1  last uop of the instruction.
- in_vl  input  VL_WIDTH  vector length (mask mode tail boundary).
- out_valid  output  1  VRF write valid.
- out_ready  input  1  VRF accepts write.
- out_vd_addr  output  5  write register index.
- out_data  output  VLENB*8  write data.
- out_we  output  VLENB  per-byte write enable.
- busy  output  1  mask accumulation in progress.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_vd_addr=0, out_data=0, out_we=0, busy=0, state=IDLE, accumulator and strobe-accumulator cleared. Reset mid-accumulation discards the partial mask.
- Handshake:
  - Transfer on in_valid&in_ready, or on out_valid&out_ready.
  - in_ready = !out_valid | out_ready. Output register refills in the same cycle it drains.
  - Latency is exactly 1 cycle from accepted last/non-mask uop to out_valid.
  - out_* hold stable while out_valid&!out_ready.
- Normal uop (in_mask_dst=0), per byte b:
  - BODY_ACTIVE: data=in_result byte, we=1.
  - BODY_INACTIVE: if vma, data=8'hFF and we=1; else data=in_old_vd byte and we=0.
  - TAIL: if vta, data=8'hFF and we=1; else data=in_old_vd byte and we=0.
  - NOT_CHANGE: data=in_old_vd byte, we=0.
  - Reserved encodings are treated as NOT_CHANGE.
- Mask uop, states IDLE and ACCUM:
  - Accepted with in_last=0:
    - acc |= in_result & in_mask_strobe; sacc |= in_mask_strobe.
    - In IDLE, the accumulate operates on cleared registers, in_vd_addr is latched, and state goes to ACCUM.
    - No output is produced.
  - Accepted with in_last=1: merge with the current acc/sacc, then emit one write. For each bit k:
    - k >= in_vl: 1 if in_vta, else old bit.
    - else if sacc[k]: acc[k].
    - else: old bit.
  - Mask write has out_we all ones, address = latched address (or in_vd_addr when the instruction is a single uop).
  - After the last uop: state=IDLE, acc and sacc cleared.
  - busy=1 exactly in ACCUM.
  - in_vl=0 with vta=0: output equals in_old_vd.
  - in_vl=VLENB*8: no tail bits.
- Protocol rules (covered by assertions, not handled in logic):
  - In ACCUM, a non-mask uop or an in_vd_addr differing from the latched address is illegal.
  - Overlapping strobes across uops OR together.

Decomposition:
- BYTE_TYPE_t encoding and UOP_OPN_BYTE_TYPE_t come from the shared rvv_backend package.
- Add to that package:
  - RETIRE_MERGE_STATE_e {IDLE, ACCUM}.
  - RETIRE_WR_t {vd_addr, data, we}.
- One natural sub-module: rvv_backend_retire_byte_sel. It is purely combinational: byte type + vta/vma -> data/we for one byte, instantiated VLENB times.
- The FSM, accumulator and output register stay in the top module.

Test Plan (VLENB=16):
- Normal uop: bytes 0-3 ACTIVE, 4-7 INACTIVE, 8-15 TAIL, vma=1, vta=0, result=0x11 repeated, old=0x22 repeated. Expected: data bytes 0-3=0x11, 4-7=0xFF, 8-15=0x22; we=0x00FF; out_valid one cycle after accept.
- Backpressure: out_ready=0 for 3 cycles with two uops queued upstream. Expected: in_ready=0 while full, first write held stable, second accepted in the same cycle the first drains.
- Mask dst, 4 uops: uop i strobes bits [32i+31:32i] with result bits alternating 1,0, in_vl=100, vta=1, old=0. Expected: a single write with bits 0-99 alternating 1,0 and bits 100-127=1; out_we=0xFFFF; busy high from cycle after uop0 until the last uop is accepted.
- Mask dst, partial strobes: strobe only bits 0-15 across 2 uops, in_vl=128, old=all ones. Expected: bits 16-127 keep 1, bits 0-15 = result.
- Reset asserted mid-ACCUM after 2 of 4 uops, then a single-uop mask instruction. Expected: busy=0 and out_valid=0 immediately; the new write contains no bits from the discarded uops.
- NOT_CHANGE prestart bytes 0-1 with vta=1 and vma=1. Expected: we[1:0]=0, data bytes 0-1 = old.

Source files
------------

// File: rtl/rvv_backend_retire_byte_merge_pkg.sv
// Shared retire-merge types: byte operand classification, merge FSM states, VRF write bundle.
// Byte classification is attached per byte by dispatch and consumed at retire.
package rvv_backend_retire_byte_merge_pkg;

  localparam int RVV_VLENB = 16;
  localparam int RVV_VLEN  = RVV_VLENB * 8;

  typedef enum logic [1:0] {
    BODY_ACTIVE   = 2'd0,
    BODY_INACTIVE = 2'd1,
    TAIL          = 2'd2,
    NOT_CHANGE    = 2'd3
  } BYTE_TYPE_t;

  typedef BYTE_TYPE_t [RVV_VLENB-1:0] UOP_OPN_BYTE_TYPE_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } RETIRE_MERGE_STATE_e;

  typedef struct packed {
    logic [4:0]           vd_addr;
    logic [RVV_VLEN-1:0]  data;
    logic [RVV_VLENB-1:0] we;
  } RETIRE_WR_t;

endpackage

// File: rtl/rvv_backend_retire_byte_merge_if.sv
// Retire-to-VRF handshake bundle; master is the surrounding pipeline, slave is the merge block.
// Holds the ROB retire uop (valid/ready), the VRF write (valid/ready) and the busy flag.
interface rvv_backend_retire_byte_merge_if #(
  parameter int VLENB    = 16,
  parameter int VL_WIDTH = $clog2(VLENB*8)+1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_vd_addr;
  logic [VLENB*8-1:0]    in_result;
  logic [VLENB*8-1:0]    in_old_vd;
  logic [VLENB*2-1:0]    in_vd_type;
  logic [VLENB*8-1:0]    in_mask_strobe;
  logic                  in_vta;
  logic                  in_vma;
  logic                  in_mask_dst;
  logic                  in_last;
  logic [VL_WIDTH-1:0]   in_vl;
  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_vd_addr;
  logic [VLENB*8-1:0]    out_data;
  logic [VLENB-1:0]      out_we;
  logic                  busy;

  modport master (
    output in_valid, in_vd_addr, in_result, in_old_vd, in_vd_type, in_mask_strobe,
           in_vta, in_vma, in_mask_dst, in_last, in_vl, out_ready,
    input  in_ready, out_valid, out_vd_addr, out_data, out_we, busy
  );

  modport slave (
    input  in_valid, in_vd_addr, in_result, in_old_vd, in_vd_type, in_mask_strobe,
           in_vta, in_vma, in_mask_dst, in_last, in_vl, out_ready,
    output in_ready, out_valid, out_vd_addr, out_data, out_we, busy
  );

endinterface

// File: rtl/rvv_backend_retire_byte_sel.sv
// One byte of retire data selection: byte class + vta/vma -> write data and enable.
// Purely combinational, no latency, no flow control.
module rvv_backend_retire_byte_sel
  import rvv_backend_retire_byte_merge_pkg::*;
(
  input  BYTE_TYPE_t  vd_type,
  input  logic [7:0]  result,
  input  logic [7:0]  old_vd,
  input  logic        vta,
  input  logic        vma,
  output logic [7:0]  data,
  output logic        we
);

  always_comb begin
    data = old_vd;
    we   = 1'b0;
    case (vd_type)
      BODY_ACTIVE: begin
        data = result;
        we   = 1'b1;
      end
      BODY_INACTIVE: begin
        if (vma) begin
          data = 8'hFF;
          we   = 1'b1;
        end
      end
      TAIL: begin
        if (vta) begin
          data = 8'hFF;
          we   = 1'b1;
        end
      end
      // NOT_CHANGE and any unknown encoding keep the old byte unwritten
      default: begin
        data = old_vd;
        we   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rvv_backend_retire_byte_merge.sv
// Retire byte merge: applies vta/vma per byte and accumulates split mask-destination uops.
// One register stage (1-cycle latency); in_ready = !out_valid | out_ready, output holds while stalled.
module rvv_backend_retire_byte_merge
  import rvv_backend_retire_byte_merge_pkg::*;
#(
  parameter int VLENB    = RVV_VLENB,
  parameter int VL_WIDTH = $clog2(VLENB*8)+1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  rvv_backend_retire_byte_merge_if.slave  rif
);

  localparam int VLEN = VLENB * 8;

  RETIRE_MERGE_STATE_e state_q, state_d;
  logic [VLEN-1:0]     acc_q, acc_d;
  logic [VLEN-1:0]     sacc_q, sacc_d;
  logic [4:0]          addr_q;
  RETIRE_WR_t          wr_q, wr_d;
  logic                out_valid_q;

  logic                accept;
  logic                mask_uop;
  logic                emit;
  logic [VL_WIDTH-1:0] vl;
  logic [VLEN-1:0]     acc_cur, sacc_cur, acc_mrg, sacc_mrg;
  logic [VLEN-1:0]     body, tail_fill, mask_data;
  logic [VLEN-1:0]     norm_data;
  logic [VLENB-1:0]    norm_we;

  assign rif.in_ready = !out_valid_q || rif.out_ready;
  assign accept       = rif.in_valid && rif.in_ready;
  assign mask_uop     = accept && rif.in_mask_dst;
  assign emit         = accept && (!rif.in_mask_dst || rif.in_last);
  assign vl           = rif.in_vl;

  for (genvar b = 0; b < VLENB; b++) begin : g_byte
    rvv_backend_retire_byte_sel u_byte_sel (
      .vd_type (BYTE_TYPE_t'(rif.in_vd_type[2*b +: 2])),
      .result  (rif.in_result[8*b +: 8]),
      .old_vd  (rif.in_old_vd[8*b +: 8]),
      .vta     (rif.in_vta),
      .vma     (rif.in_vma),
      .data    (norm_data[8*b +: 8]),
      .we      (norm_we[b])
    );
  end

  // The first uop of an instruction merges into cleared state even if stale bits linger.
  always_comb begin
    acc_cur   = (state_q == ACCUM) ? acc_q  : '0;
    sacc_cur  = (state_q == ACCUM) ? sacc_q : '0;
    acc_mrg   = acc_cur | (rif.in_result & rif.in_mask_strobe);
    sacc_mrg  = sacc_cur | rif.in_mask_strobe;
    body      = '0;
    for (int k = 0; k < VLEN; k++) begin
      body[k] = (k < int'(vl));
    end
    tail_fill = rif.in_vta ? '1 : rif.in_old_vd;
    mask_data = (body & ((sacc_mrg & acc_mrg) | (~sacc_mrg & rif.in_old_vd)))
              | (~body & tail_fill);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sacc_d  = sacc_q;
    if (mask_uop) begin
      if (rif.in_last) begin
        state_d = IDLE;
        acc_d   = '0;
        sacc_d  = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_mrg;
        sacc_d  = sacc_mrg;
      end
    end
    wr_d.vd_addr = (state_q == ACCUM && rif.in_mask_dst) ? addr_q : rif.in_vd_addr;
    wr_d.data    = rif.in_mask_dst ? mask_data : norm_data;
    wr_d.we      = rif.in_mask_dst ? '1 : norm_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sacc_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sacc_q  <= sacc_d;
      if (mask_uop && !rif.in_last && state_q == IDLE) begin
        addr_q <= rif.in_vd_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      wr_q        <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      wr_q        <= wr_d;
    end else if (rif.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign rif.out_valid   = out_valid_q;
  assign rif.out_vd_addr = wr_q.vd_addr;
  assign rif.out_data    = wr_q.data;
  assign rif.out_we      = wr_q.we;
  assign rif.busy        = (state_q == ACCUM);

  // An open mask accumulation only accepts further uops of the same mask instruction.
  a_accum_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACCUM && rif.in_valid) |-> (rif.in_mask_dst && rif.in_vd_addr == addr_q));

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !rif.out_ready) |=> (out_valid_q && $stable(wr_q)));

endmodule

// File: tb/tb_rvv_backend_retire_byte_merge.sv
// Randomised and directed retire traffic against an instruction-level reference model.
module tb_rvv_backend_retire_byte_merge;
  import rvv_backend_retire_byte_merge_pkg::*;

  localparam int VLENB = 16;
  localparam int VLEN  = 128;
  localparam int VLW   = 8;

  typedef struct packed {
    logic [4:0]       addr;
    logic [VLEN-1:0]  data;
    logic [VLENB-1:0] we;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rvv_backend_retire_byte_merge_if #(.VLENB(VLENB), .VL_WIDTH(VLW)) ifc();

  rvv_backend_retire_byte_merge #(.VLENB(VLENB), .VL_WIDTH(VLW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rif   (ifc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  exp_t            exp_q[$];
  exp_t            last_exp;
  bit              model_busy = 0;
  logic [4:0]      model_addr;
  logic [VLEN-1:0] mval, mset;
  bit              rand_rdy  = 0;
  bit              force_rdy = 1;
  bit              mon_en    = 0;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [VLEN-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic exp_t model_normal(input logic [4:0] a, input logic [VLEN-1:0] res,
                                        input logic [VLEN-1:0] old, input logic [2*VLENB-1:0] vt,
                                        input logic vta, input logic vma);
    exp_t e;
    e.addr = a;
    e.data = old;
    e.we   = '0;
    for (int b = 0; b < VLENB; b++) begin
      logic [1:0] t;
      t = vt[2*b +: 2];
      if (t == BODY_ACTIVE) begin
        e.data[8*b +: 8] = res[8*b +: 8];
        e.we[b] = 1'b1;
      end else if ((t == BODY_INACTIVE && vma) || (t == TAIL && vta)) begin
        e.data[8*b +: 8] = 8'hFF;
        e.we[b] = 1'b1;
      end
    end
    return e;
  endfunction

  // Called at the accepting clock edge, using the stimulus the bench itself drove.
  task automatic model_accept();
    exp_t e;
    if (!ifc.in_mask_dst) begin
      last_exp = model_normal(ifc.in_vd_addr, ifc.in_result, ifc.in_old_vd, ifc.in_vd_type,
                              ifc.in_vta, ifc.in_vma);
      exp_q.push_back(last_exp);
    end else begin
      if (!model_busy) begin
        model_addr = ifc.in_vd_addr;
        mval = '0;
        mset = '0;
      end
      for (int k = 0; k < VLEN; k++) begin
        if (ifc.in_mask_strobe[k]) begin
          mset[k] = 1'b1;
          if (ifc.in_result[k]) mval[k] = 1'b1;
        end
      end
      if (ifc.in_last) begin
        e.addr = model_addr;
        e.we   = '1;
        for (int k = 0; k < VLEN; k++) begin
          if (k >= int'(ifc.in_vl)) e.data[k] = ifc.in_vta ? 1'b1 : ifc.in_old_vd[k];
          else                      e.data[k] = mset[k] ? mval[k] : ifc.in_old_vd[k];
        end
        exp_q.push_back(e);
        last_exp   = e;
        model_busy = 0;
      end else begin
        model_busy = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uop(input logic [4:0] a, input logic [VLEN-1:0] res, input logic [VLEN-1:0] old,
                           input logic [2*VLENB-1:0] vt, input logic [VLEN-1:0] strb,
                           input logic vta, input logic vma, input logic mdst, input logic last,
                           input logic [VLW-1:0] vl);
    ifc.in_vd_addr     = a;
    ifc.in_result      = res;
    ifc.in_old_vd      = old;
    ifc.in_vd_type     = vt;
    ifc.in_mask_strobe = strb;
    ifc.in_vta         = vta;
    ifc.in_vma         = vma;
    ifc.in_mask_dst    = mdst;
    ifc.in_last        = last;
    ifc.in_vl          = vl;
    ifc.in_valid       = 1'b1;
  endtask

  task automatic wait_accept(output bit accepted);
    int  n = 0;
    bit  done = 0;
    logic rd;
    accepted = 0;
    while (!done) begin
      @(negedge clk);
      rd = ifc.in_ready;
      @(posedge clk);
      if (rd === 1'b1) begin
        accepted = 1;
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          vectors++;
          miscompares++;
          $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", n);
          done = 1;
        end
      end
    end
  endtask

  task automatic send(input logic [4:0] a, input logic [VLEN-1:0] res, input logic [VLEN-1:0] old,
                      input logic [2*VLENB-1:0] vt, input logic [VLEN-1:0] strb,
                      input logic vta, input logic vma, input logic mdst, input logic last,
                      input logic [VLW-1:0] vl);
    bit acc;
    drive_uop(a, res, old, vt, strb, vta, vma, mdst, last, vl);
    wait_accept(acc);
    if (acc) model_accept();
    #1;
    ifc.in_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    ifc.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  // Monitor: pops the scoreboard on each VRF write and checks hold-while-stalled.
  exp_t held_v;
  bit   held = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", ifc.busy, model_busy);
      if (ifc.out_valid) begin
        if (held) begin
          chk("hold_addr", ifc.out_vd_addr, held_v.addr);
          chk("hold_data", ifc.out_data, held_v.data);
          chk("hold_we", ifc.out_we, held_v.we);
        end
        if (ifc.out_ready) begin
          held = 0;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got write to v%0d, expected none", ifc.out_vd_addr);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", ifc.out_vd_addr, e.addr);
            chk("wr_data", ifc.out_data, e.data);
            chk("wr_we", ifc.out_we, e.we);
          end
        end else begin
          held = 1;
          held_v.addr = ifc.out_vd_addr;
          held_v.data = ifc.out_data;
          held_v.we   = ifc.out_we;
        end
      end else begin
        held = 0;
      end
    end
  end

  logic [2*VLENB-1:0] vt;
  logic [VLEN-1:0]    req, alt, old_v;
  exp_t               exp_a, exp_b;

  initial begin
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    drive_uop('0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    ifc.in_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_addr", ifc.out_vd_addr, 0);
    chk("rst_data", ifc.out_data, 0);
    chk("rst_we", ifc.out_we, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;
    cyc();

    // Normal uop: 0-3 active, 4-7 inactive, 8-15 tail, vma=1 vta=0
    for (int b = 0; b < VLENB; b++)
      vt[2*b +: 2] = (b < 4) ? BODY_ACTIVE : (b < 8) ? BODY_INACTIVE : TAIL;
    send(5'd3, {16{8'h11}}, {16{8'h22}}, vt, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("lat_valid", ifc.out_valid, 1);
    chk("norm_data", ifc.out_data, 128'h2222222222222222_FFFFFFFF_11111111);
    chk("norm_we", ifc.out_we, 16'h00FF);
    cyc();

    // NOT_CHANGE prestart bytes with both agnostic policies
    vt = $urandom;
    vt[3:0] = {NOT_CHANGE, NOT_CHANGE};
    old_v = rnd128();
    send(5'd4, rnd128(), old_v, vt, '0, 1'b1, 1'b1, 1'b0, 1'b1, '0);
    chk("nc_we", ifc.out_we[1:0], 2'b00);
    chk("nc_data", ifc.out_data[15:0], old_v[15:0]);
    cyc();

    // Backpressure: first write stalls three cycles, second refills as it drains
    force_rdy = 0;
    cyc();
    cyc();
    send(5'd6, rnd128(), rnd128(), $urandom, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    exp_a = last_exp;
    drive_uop(5'd7, rnd128(), rnd128(), $urandom, '0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", ifc.in_ready, 0);
      chk("bp_first_held", ifc.out_data, exp_a.data);
      @(posedge clk);
    end
    #1 force_rdy = 1;
    @(negedge clk);
    chk("bp_in_ready_high", ifc.in_ready, 1);
    @(posedge clk);
    model_accept();
    exp_b = last_exp;
    #1;
    ifc.in_valid = 1'b0;
    chk("bp_refill_valid", ifc.out_valid, 1);
    chk("bp_refill_data", ifc.out_data, exp_b.data);
    cyc();

    // Mask destination split over 4 uops, vl=100, vta=1
    for (int k = 0; k < VLEN; k++) alt[k] = (k % 2 == 0);
    for (int i = 0; i < 4; i++) begin
      req = '0;
      req[32*i +: 32] = '1;
      send(5'd9, alt, '0, '0, req, 1'b1, 1'b0, 1'b1, (i == 3), 8'd100);
    end
    for (int k = 0; k < VLEN; k++) req[k] = (k >= 100) ? 1'b1 : (k % 2 == 0);
    chk("m4_data", ifc.out_data, req);
    chk("m4_we", ifc.out_we, 16'hFFFF);
    chk("m4_addr", ifc.out_vd_addr, 5'd9);
    cyc();

    // Partial strobes: only bits 0-15 written, old all ones
    alt = rnd128();
    send(5'd10, alt, '1, '0, 128'h00FF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd128);
    send(5'd10, alt, '1, '0, 128'hFF00, 1'b0, 1'b0, 1'b1, 1'b1, 8'd128);
    req = '1;
    req[15:0] = alt[15:0];
    chk("partial_data", ifc.out_data, req);
    cyc();

    // vl=0 with vta=0 leaves the register unchanged
    old_v = rnd128();
    send(5'd11, rnd128(), old_v, '0, rnd128(), 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("vl0_data", ifc.out_data, old_v);
    cyc();

    // Reset mid-accumulation discards the partial mask
    send(5'd12, '1, '0, '0, '1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd128);
    send(5'd12, '1, '0, '0, '1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd128);
    cyc();
    rst_n = 1'b0;
    model_busy = 0;
    #1;
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_valid", ifc.out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    send(5'd13, '0, '0, '0, 128'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'd128);
    chk("post_rst_data", ifc.out_data, '0);
    chk("post_rst_addr", ifc.out_vd_addr, 5'd13);
    cyc();

    // Random traffic with random backpressure
    rand_rdy = 1;
    for (int n = 0; n < 150; n++) begin
      logic [4:0] a;
      a = 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        send(a, rnd128(), rnd128(), $urandom, rnd128(), 1'($urandom), 1'($urandom),
             1'b0, 1'b1, '0);
      end else begin
        int nu;
        nu = $urandom_range(1, 4);
        for (int u = 0; u < nu; u++) begin
          send(a, rnd128(), rnd128(), $urandom, rnd128(), 1'($urandom), 1'($urandom),
               1'b1, (u == nu - 1), 8'($urandom_range(0, 128)));
          if ($urandom_range(0, 3) == 0) cyc();
        end
      end
      if ($urandom_range(0, 3) == 0) cyc();
    end
    rand_rdy = 0;
    force_rdy = 1;
    for (int i = 0; i < 1000 && exp_q.size() > 0; i++) cyc();
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) cyc();
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
